// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants, edge type and counter-width helper for the debounce bank
package debounce_pkg;

    localparam int DB_STABLE_CYCLES_DEF = 16;
    localparam int DB_SYNC_STAGES_DEF   = 2;
    localparam int DB_GLITCH_CNT_W      = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } db_edge_t;

    // Stability counter width; a single-cycle filter still needs one bit.
    function automatic int db_cnt_w(input int stable_cycles);
        return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one debounce channel: synchroniser, stability counter, level and edge strobes (glitch flag with DEBOUNCE_BANK_GLITCH_CNT_EN)
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter int   SYNC_STAGES   = DB_SYNC_STAGES_DEF,
    parameter logic RESET_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
    output logic glitch,
`endif
    output logic accept
);

    localparam int            CW       = db_cnt_w(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   out_d;
    db_edge_t               edge_q;
    db_edge_t               edge_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; the last stage is the value the filter judges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    // Filter decision: a mismatch must survive STABLE_CYCLES cycles; an early match is a rejected glitch.
    always_comb begin
        cnt_d  = cnt_q;
        out_d  = out;
        edge_d = NONE;
        accept = 1'b0;
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        glitch = 1'b0;
`endif
        if (s == out) begin
            cnt_d = '0;
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
            glitch = (cnt_q != '0);
`endif
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            out_d  = s;
            accept = 1'b1;
            edge_d = s ? RISE : FALL;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Filter state: counter, accepted level and the registered edge that drives the strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            out    <= RESET_VAL;
            edge_q <= NONE;
        end else begin
            cnt_q  <= cnt_d;
            out    <= out_d;
            edge_q <= edge_d;
        end
    end

    assign rise = (edge_q == RISE);
    assign fall = (edge_q == FALL);

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with any_change flag; DEBOUNCE_BANK_GLITCH_CNT_EN adds glitch_clr/glitch_cnt
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   WIDTH         = 4,
    parameter int   STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter int   SYNC_STAGES   = DB_SYNC_STAGES_DEF,
    parameter logic RESET_VAL     = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
    input  logic                       glitch_clr,
    output logic [DB_GLITCH_CNT_W-1:0] glitch_cnt,
`endif
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic [WIDTH-1:0]           rise,
    output logic [WIDTH-1:0]           fall,
    output logic                       any_change
);

    logic [WIDTH-1:0] accept;
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
    logic [WIDTH-1:0] glitch_vec;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_VAL     (RESET_VAL)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .in     (in[i]),
            .out    (out[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
            .glitch (glitch_vec[i]),
`endif
            .accept (accept[i])
        );
    end

    // any_change is registered from the same acceptances that set the strobes, so it lines up with them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |accept;
        end
    end

`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
    localparam int                SUM_W   = DB_GLITCH_CNT_W + $clog2(WIDTH + 1);
    localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'({DB_GLITCH_CNT_W{1'b1}});

    logic [SUM_W-1:0] glitch_sum;
    logic [SUM_W-1:0] glitch_tot;

    // Several channels may reject in one cycle; add them all, wide enough to detect overflow.
    always_comb begin
        glitch_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            glitch_sum = glitch_sum + SUM_W'(glitch_vec[i]);
        end
        glitch_tot = SUM_W'(glitch_cnt) + glitch_sum;
    end

    // Saturating diagnostic counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (glitch_clr) begin
            glitch_cnt <= '0;
        end else if (glitch_tot > CNT_MAX) begin
            glitch_cnt <= '1;
        end else begin
            glitch_cnt <= glitch_tot[DB_GLITCH_CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank (glitch counter checks with DEBOUNCE_BANK_GLITCH_CNT_EN)
module tb_debounce_bank;

    localparam int LAT = 18;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in  = 4'b0000;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_change;
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
    logic        glitch_clr = 1'b0;
    logic [15:0] glitch_cnt;
    logic [15:0] g0;
`endif

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] o;
    } exp_t;

    exp_t sb[$];

    debounce_bank #(
        .WIDTH         (4),
        .STABLE_CYCLES (16),
        .SYNC_STAGES   (2),
        .RESET_VAL     (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt),
`endif
        .in         (in),
        .out        (out),
        .rise       (rise),
        .fall       (fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Input driven now (edge count cyc) is first sampled at the next edge and accepted LAT edges later.
    task automatic expect_edge(input logic [3:0] r, input logic [3:0] f, input logic [3:0] o);
        exp_t e;
        e.cyc = cyc + LAT;
        e.r   = r;
        e.f   = f;
        e.o   = o;
        sb.push_back(e);
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard, in the right cycle.
    always @(negedge clk) begin
        logic [3:0] strobe;
        exp_t       e;
        strobe = rise | fall;
        check_eq("any_change", {31'd0, any_change}, {31'd0, (strobe != 4'd0)});
        if (strobe != 4'd0) begin
            check_eq("rise_fall_excl", {28'd0, rise & fall}, 32'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_strobe", {28'd0, strobe}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("strobe_cycle", cyc, e.cyc);
                check_eq("rise", {28'd0, rise}, {28'd0, e.r});
                check_eq("fall", {28'd0, fall}, {28'd0, e.f});
                check_eq("out_at_strobe", {28'd0, out}, {28'd0, e.o});
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            check_eq("missing_strobe", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
    end

    initial begin
        // Reset with all inputs low: outputs idle high, no strobes.
        rst = 1'b0;
        in  = 4'b0000;
        tick(3);
        check_eq("reset_out", {28'd0, out}, 32'hF);
        check_eq("reset_rise", {28'd0, rise}, 32'h0);
        check_eq("reset_fall", {28'd0, fall}, 32'h0);
        check_eq("reset_any", {31'd0, any_change}, 32'h0);
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        check_eq("reset_gcnt", {16'd0, glitch_cnt}, 32'h0);
`endif
        rst = 1'b1;
        expect_edge(4'h0, 4'hF, 4'h0);
        tick(17);
        check_eq("release_pre_latency", {28'd0, out}, 32'hF);
        tick(8);

        // Accepted rising edge on ch0, exact latency.
        in = 4'b0001;
        expect_edge(4'h1, 4'h0, 4'h1);
        tick(17);
        check_eq("ch0_pre_latency", {28'd0, out}, 32'h0);
        tick(8);

        // 15-cycle pulse on ch1 is rejected.
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        g0 = glitch_cnt;
`endif
        in = 4'b0011;
        tick(15);
        in = 4'b0001;
        tick(25);
        check_eq("glitch15_out", {28'd0, out}, 32'h1);
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        check_eq("glitch15_cnt", {16'd0, glitch_cnt}, {16'd0, g0 + 16'd1});
`endif

        // 16-cycle pulse on ch1 is the shortest accepted one.
        in = 4'b0011;
        expect_edge(4'h2, 4'h0, 4'h3);
        tick(16);
        in = 4'b0001;
        expect_edge(4'h0, 4'h2, 4'h1);
        tick(25);

        // ch0 falls.
        in = 4'b0000;
        expect_edge(4'h0, 4'h1, 4'h0);
        tick(25);

        // ch0 accepts on the same edge that ch2 and ch3 reject glitches.
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        g0 = glitch_cnt;
`endif
        in = 4'b1101;
        expect_edge(4'h1, 4'h0, 4'h1);
        tick(15);
        in = 4'b0001;
        tick(3);
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        check_eq("simul_gcnt", {16'd0, glitch_cnt}, {16'd0, g0 + 16'd2});
`endif
        tick(20);
        check_eq("simul_out", {28'd0, out}, 32'h1);

`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        // Four rejections per one-cycle pulse drive the counter into saturation.
        for (int i = 0; i < 16384; i++) begin
            in = 4'b1110;
            tick(1);
            in = 4'b0001;
            tick(1);
        end
        tick(5);
        check_eq("gcnt_sat", {16'd0, glitch_cnt}, 32'hFFFF);
        in = 4'b1110;
        tick(1);
        in = 4'b0001;
        tick(5);
        check_eq("gcnt_sat_hold", {16'd0, glitch_cnt}, 32'hFFFF);
        // Clear lands on the edge where four more rejections happen.
        in = 4'b1110;
        tick(1);
        in = 4'b0001;
        tick(2);
        glitch_clr = 1'b1;
        tick(1);
        glitch_clr = 1'b0;
        check_eq("gcnt_clr", {16'd0, glitch_cnt}, 32'h0);
        tick(5);
        check_eq("gcnt_clr_hold", {16'd0, glitch_cnt}, 32'h0);
        check_eq("sat_out", {28'd0, out}, 32'h1);
`endif

        // Reset ten cycles into a pending ch1 change: candidate discarded.
        in = 4'b0011;
        tick(10);
        rst = 1'b0;
        #1;
        check_eq("midrst_out", {28'd0, out}, 32'hF);
        check_eq("midrst_rise", {28'd0, rise}, 32'h0);
        check_eq("midrst_fall", {28'd0, fall}, 32'h0);
        check_eq("midrst_any", {31'd0, any_change}, 32'h0);
`ifdef DEBOUNCE_BANK_GLITCH_CNT_EN
        check_eq("midrst_gcnt", {16'd0, glitch_cnt}, 32'h0);
`endif
        tick(3);
        rst = 1'b1;
        expect_edge(4'h0, 4'hC, 4'h3);
        tick(17);
        check_eq("midrst_pre_latency", {28'd0, out}, 32'hF);
        tick(10);
        check_eq("midrst_final_out", {28'd0, out}, 32'h3);

        check_eq("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel, parametrised debouncer and synchroniser for asynchronous inputs such as buttons, switches and open-drain bus lines. It sits between the FPGA pins and the I2C monitor and control logic. Each channel has its own synchroniser chain and stability counter, and produces a filtered level plus single-cycle rise and fall strobes. An optional rejected-glitch counter is available for line-quality diagnostics.

## Interface
Parameters:
- `WIDTH`, default 4: number of independent channels; minimum 1.
- `STABLE_CYCLES`, default 16: consecutive cycles a new synchronised value must persist before it is accepted; minimum 1.
- `SYNC_STAGES`, default 2: synchroniser flops per channel; minimum 2.
- `RESET_VAL`, default 1'b1: reset value of sync flops and `out`, applied to every channel. The default matches idle-high I2C lines.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst`, input, 1: reset, asynchronous assert, active-low.
- `in`, input, WIDTH: raw asynchronous inputs.
- `out`, output, WIDTH: debounced levels.
- `rise`, output, WIDTH: one-cycle strobe when `out[i]` goes 0→1.
- `fall`, output, WIDTH: one-cycle strobe when `out[i]` goes 1→0.
- `any_change`, output, 1: registered OR of all `rise` and `fall` bits.
- `glitch_clr`, input, 1: synchronous clear of `glitch_cnt`. Present only with `DEBOUNCE_BANK_GLITCH_CNT_EN`.
- `glitch_cnt`, output, 16: saturating count of rejected glitches. Present only with `DEBOUNCE_BANK_GLITCH_CNT_EN`.

## Operation
- Reset while `rst`=0, asynchronous:
  - sync flops and `out` are set to `RESET_VAL`;
  - counters, `rise`, `fall`, `any_change` and `glitch_cnt` are set to 0.
- Per channel i, `s[i]` is the last synchroniser stage.
- Two states per channel, implied by the counter:
  - **STABLE**: `cnt`=0 and `s`==`out`.
  - **PENDING**: `s`!=`out`, or `cnt`≠0.
- Each cycle, per channel:
  - If `s`==`out`: set `cnt` to 0. If `cnt` was ≠0, this is a rejected glitch and the channel returns to STABLE.
  - If `s`!=`out` and `cnt`<`STABLE_CYCLES`-1: increment `cnt`.
  - If `s`!=`out` and `cnt`==`STABLE_CYCLES`-1: set `out` to `s`, set `cnt` to 0, and pulse `rise` or `fall` for exactly one cycle.
- Counter width is $clog2(`STABLE_CYCLES`), minimum 1 bit. The counter never wraps, because it clears on acceptance.
- `rise` and `fall` are registered and mutually exclusive per channel. They are never both high on the same cycle.
- Channels are fully independent. Any number of channels may accept on the same cycle.
- `any_change` is asserted on the same cycle as the strobes that cause it.

## Timing
- Latency: a change on `in[i]` first sampled at edge 1 and held stable appears on `out[i]` at edge `SYNC_STAGES`+`STABLE_CYCLES`. With defaults, that is edge 18.
- `rise` and `fall` are asserted during the cycle following that edge, for exactly one cycle.
- Minimum accepted pulse width on `s`: `STABLE_CYCLES` cycles. A run of `STABLE_CYCLES`-1 cycles is always rejected.
- `STABLE_CYCLES`=1: `out` tracks `s` with one cycle of delay, and no glitch is ever counted.
- Reset deassertion mid-PENDING: the candidate is discarded and counting restarts from `RESET_VAL`. A mismatching input after reset produces a normal accepted edge after full latency.
- `rst` has no synchroniser inside this block. Deassertion must already be synchronous to `clk`, which is guaranteed by the top-level reset bridge.

## Configuration
- `DEBOUNCE_BANK_GLITCH_CNT_EN` defined:
  - `glitch_cnt` increments by the number of channels rejecting a glitch in that cycle.
  - The count saturates at 16'hFFFF.
  - `glitch_clr` forces 0 and has priority over any same-cycle increments.
- Not defined: `glitch_clr` and `glitch_cnt` ports are absent, and no counter logic is synthesised.

## Structure
- Package `debounce_pkg`:
  - default constants `DB_STABLE_CYCLES_DEF`=16, `DB_SYNC_STAGES_DEF`=2, `DB_GLITCH_CNT_W`=16;
  - a `db_edge_t` typedef (NONE, RISE, FALL) used internally.
- Sub-module `debounce_chan`: one channel, comprising synchroniser, counter, `out` and edge strobe, plus a `glitch` flag output.
  - `debounce_bank` generates `WIDTH` instances of it.
  - `debounce_bank` holds `any_change` and the glitch counter, which sums the `glitch` flags.

## Test plan
- **Reset:** `WIDTH`=4, `RESET_VAL`=1, `in`=4'b0000 during reset. Expect `out`=4'hF, strobes 0. After release, `out` becomes 4'h0 at edge 18, with `fall`=4'hF for one cycle and `any_change`=1.
- **Accepted edge:** ch0 0→1, held. Expect `out[0]`=1 exactly at edge 18, `rise[0]`=1 for one cycle, other channels unchanged.
- **Glitch:** ch1 pulsed for 15 cycles with defaults. Expect `out[1]` unchanged, no strobe, and `glitch_cnt` incrementing 0→1 (macro on).
- **Simultaneous events:** ch2 and ch3 glitch on the same cycle while ch0 accepts. Expect `glitch_cnt` +2, `rise[0]` only, and `any_change`=1.
- **Saturation and clear:** preload via 65536 glitches. Expect `glitch_cnt`=16'hFFFF, held there. Assert `glitch_clr` on an incrementing cycle and expect 0.
- **Reset mid-operation:** assert `rst` at cycle 10 of a pending change. Expect immediate `out`=`RESET_VAL` and no strobe. After release, the full 18-cycle latency applies.
